aes_state_unload: RTL
=====================

Name: aes_state_unload

Overview:
- Output end of the AES datapath. Accepts a 128-bit state whose rows are held in ShiftRows-permuted order (the layout the plaintext input register produces).
- Applies the inverse row permutation to recover the natural-order ciphertext block and holds it in a 128-bit register.
- Streams that block out one byte at a time over a valid/ready handshake, with backpressure.

Parameters:
- MSB_FIRST, 1, 1: byte 0 (bits [127:120]) is sent first; 0: byte 15 (bits [7:0]) is sent first.

Ports:
- clk  in  1  clock; all flops update on its rising edge
- rst  in  1  asynchronous reset, active-low
- valid_in  in  1  state_in is valid this cycle
- state_in  in  128  row-permuted AES state; byte idx = state_in[127-8*idx -: 8]
- in_ready  out  1  block accepted when valid_in && in_ready
- dout  out  8  current output byte
- dout_valid  out  1  dout holds a valid byte
- dout_last  out  1  marks the 16th byte of a block; only meaningful with dout_valid
- dout_ready  in  1  downstream accepts dout when dout_valid && dout_ready
- cipher_out  out  128  most recently captured un-permuted block; held until the next capture

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; byte counter = 0.
  - cipher_out = 0, dout_valid = 0, dout_last = 0, dout = 0.
  - in_ready is 1 as soon as rst is deasserted.
  - Reset during SEND discards the partial block; no further bytes of it are emitted.
- Index mapping, byte index j = 0..15: row r = j[1:0], column k = j[3:2].
- Un-permute: cipher byte j = state_in byte 4*((k - r) mod 4) + r, using 2-bit wrap arithmetic. The mapping is pure wiring, applied at capture.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready = 1.
  - On valid_in: capture the un-permuted block into cipher_out, counter = 0, go to SEND.
  - No valid_in: stay in IDLE.
- SEND:
  - dout_valid = 1.
  - dout = cipher_out byte cnt if MSB_FIRST, else byte 15-cnt.
  - dout_last = (cnt == 15).
  - dout_valid && !dout_ready: dout, dout_last and cnt hold stable for any number of cycles.
  - Accept with cnt < 15: cnt increments.
  - Accept with cnt == 15 and valid_in = 0: go to IDLE.
  - Accept with cnt == 15 and valid_in = 1: capture the new block, cnt = 0, stay in SEND. There is no bubble.
- in_ready = IDLE || (SEND && cnt == 15 && dout_ready). This is a combinational path from dout_ready.
- Timing:
  - Latency: first byte is valid the cycle after capture.
  - Throughput: 16 cycles per block with back-to-back input and dout_ready held at 1.
  - Block boundary: an accepted byte 15 with an idle input gives one dout_valid=0 cycle.
- valid_in while in_ready=0 is ignored. Upstream must hold valid_in and state_in until accepted.
- dout is 0 whenever dout_valid = 0.
- cipher_out changes only on capture.
- The counter is 4 bits and never wraps silently; returning to 0 happens only via capture.

Decomposition:
- Shared package aes_pkg: AES_BLOCK_W=128, AES_BYTES=16, AES_NB=4, and a function for the byte-index mapping (row/column extract plus the shift) shared with the input register.
- One natural sub-module: aes_inv_shift_rows, a combinational 128-bit permutation instantiated at the capture point. The FSM, counter and byte mux stay in the top level.

Test Plan:
- Identity pattern: state_in = 000102030405060708090a0b0c0d0e0f, valid_in 1 cycle, dout_ready = 1.
  - cipher_out = 000d0a0704010e0b0805020f0c090603.
  - Bytes 00,0d,0a,07,04,01,0e,0b,08,05,02,0f,0c,09,06,03 on 16 consecutive cycles; dout_last only on 03.
  - First dout_valid the cycle after capture.
- Backpressure: same block, dout_ready toggled 1,0,0,1,...
  - dout holds 0d through both stall cycles.
  - Exactly 16 bytes emitted, in order, none dropped or duplicated.
- Back-to-back: two blocks with valid_in held, dout_ready = 1.
  - in_ready pulses on the cycle byte 15 of block 1 is accepted.
  - Block 2 byte 0 follows on the next cycle; 32 contiguous valid cycles.
- MSB_FIRST=0 build, identity block: bytes 03,06,09,0c,0f,02,05,08,0b,0e,01,04,07,0a,0d,00.
- Async reset at cnt=7 (asserted between clock edges):
  - dout_valid, cipher_out and dout go to 0 immediately, without waiting for a clock edge.
  - After release: in_ready = 1 and no residual bytes are emitted.
  - The next block streams from byte 0.
- Ignored input: valid_in pulsed with a different state_in while in SEND (cnt 3..14). The stream and cipher_out are unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the ShiftRows byte-index mapping used by the
// input register and the unload stage.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTES   = 16;
  localparam int unsigned AES_NB      = 4;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } unload_state_e;

  function automatic logic [1:0] idx_row(input logic [3:0] j);
    return j[1:0];
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] j);
    return j[3:2];
  endfunction

  // Natural byte j (row r, column k) lives at column (k - r) mod 4 of the permuted state.
  function automatic logic [3:0] inv_shift_idx(input logic [3:0] j);
    logic [1:0] w_r;
    logic [1:0] w_c;
    w_r = idx_row(j);
    w_c = idx_col(j) - w_r;
    return {w_c, w_r};
  endfunction

endpackage

// File: rtl/aes_inv_shift_rows.sv
// Combinational inverse ShiftRows: maps a row-permuted AES state back to natural order.
module aes_inv_shift_rows
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_state,
  output logic [AES_BLOCK_W-1:0] o_state
);

  for (genvar j = 0; j < AES_BYTES; j++) begin : g_byte
    localparam int unsigned Src = int'(inv_shift_idx(4'(j)));
    assign o_state[AES_BLOCK_W-1-8*j -: 8] = i_state[AES_BLOCK_W-1-8*Src -: 8];
  end

endmodule

// File: rtl/aes_state_unload.sv
// AES output stage: un-permutes a captured state and streams it out byte by byte
// over a valid/ready handshake.
module aes_state_unload
  import aes_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [AES_BLOCK_W-1:0] state_in,
  output logic                   in_ready,
  output logic [7:0]             dout,
  output logic                   dout_valid,
  output logic                   dout_last,
  input  logic                   dout_ready,
  output logic [AES_BLOCK_W-1:0] cipher_out
);

  unload_state_e          r_state;
  logic [3:0]             r_cnt;
  logic [AES_BLOCK_W-1:0] r_cipher;
  logic [7:0]             r_dout;
  logic                   r_dout_valid;
  logic                   r_dout_last;

  logic [AES_BLOCK_W-1:0] w_unperm;
  logic                   w_cnt_last;
  logic                   w_capture;

  aes_inv_shift_rows u_inv_shift_rows (
    .i_state (state_in),
    .o_state (w_unperm)
  );

  // Stream position idx maps to block byte idx (MSB first) or 15-idx; the bit offset
  // of block byte b is 8*(15-b), i.e. {~b, 3'b000}.
  function automatic logic [7:0] pick_byte(input logic [AES_BLOCK_W-1:0] blk,
                                           input logic [3:0] idx);
    logic [3:0] w_pos;
    w_pos = MSB_FIRST ? ~idx : idx;
    return blk[{w_pos, 3'b000} +: 8];
  endfunction

  assign w_cnt_last = (r_cnt == 4'd15);
  // Ready also at the final byte's handshake so a waiting block is taken with no bubble.
  assign in_ready   = (r_state == StIdle) || (w_cnt_last && dout_ready);
  assign w_capture  = valid_in && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_cipher     <= '0;
      r_dout       <= 8'd0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else if (w_capture) begin
      r_state      <= StSend;
      r_cnt        <= 4'd0;
      r_cipher     <= w_unperm;
      r_dout       <= pick_byte(w_unperm, 4'd0);
      r_dout_valid <= 1'b1;
      r_dout_last  <= 1'b0;
    end else if (r_state == StSend && dout_ready) begin
      if (!w_cnt_last) begin
        r_cnt       <= r_cnt + 4'd1;
        r_dout      <= pick_byte(r_cipher, r_cnt + 4'd1);
        r_dout_last <= (r_cnt == 4'd14);
      end else begin
        r_state      <= StIdle;
        r_dout       <= 8'd0;
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign cipher_out = r_cipher;

endmodule
